// File: rtl/fifo_reader_pkg.sv
// Shared types and sizing for the FIFO read-side controller.
//   rd_state_e : controller FSM states
//   SKID_DEPTH : number of skid buffer entries
//   OCC_W      : width of the skid buffer occupancy count
package fifo_reader_pkg;

  localparam int unsigned SKID_DEPTH = 3;
  localparam int unsigned OCC_W      = 2;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } rd_state_e;

endpackage : fifo_reader_pkg

// File: rtl/fifo_skid_buf.sv
// Three-entry register FIFO that soaks up the upstream read latency.
//   clk, rst_n  : clock, async active-low reset
//   clear_i     : drop all entries (wins over push/pop)
//   push_i      : write push_data_i at the tail
//   pop_i       : drop the head entry
//   head_o      : head entry (entry 0), 0 after reset
//   occ_o       : number of valid entries, 0..3
module fifo_skid_buf
  import fifo_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [OCC_W-1:0] occ_o
);

  logic [WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [OCC_W-1:0] occ_q;
  logic             pop_ok;
  logic             push_ok;
  logic [OCC_W-1:0] wr_idx;

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(SKID_DEPTH);

  assign pop_ok  = pop_i && (occ_q != '0);
  assign push_ok = push_i && ((occ_q != OCC_FULL) || pop_ok);
  // Tail slot after any same-cycle shift of the head.
  assign wr_idx  = occ_q - OCC_W'(pop_ok);

  // Shift-register storage: entry 0 is always the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q    <= '0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      mem_q[2] <= '0;
    end else if (clear_i) begin
      occ_q <= '0;
    end else begin
      if (pop_ok) begin
        mem_q[0] <= mem_q[1];
        mem_q[1] <= mem_q[2];
      end
      // Placed after the shift so a write to the vacated slot wins.
      if (push_ok) begin
        case (wr_idx)
          2'd0:    mem_q[0] <= push_data_i;
          2'd1:    mem_q[1] <= push_data_i;
          default: mem_q[2] <= push_data_i;
        endcase
      end
      occ_q <= occ_q + OCC_W'(push_ok) - OCC_W'(pop_ok);
    end
  end

  assign head_o = mem_q[0];
  assign occ_o  = occ_q;

  // A push into a full buffer with no pop means the read throttle is broken.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !pop_ok && !clear_i && (occ_q == OCC_FULL)));

endmodule : fifo_skid_buf

// File: rtl/fifo_reader.sv
// Drains a one-cycle-latency synchronous FIFO into a valid/ready stream.
//   clk, rst_n            : clock, async active-low reset
//   fifo_empty/rd_en/data : upstream FIFO read port (data valid cycle after read)
//   m_valid/ready/data    : output stream, m_data is the skid buffer head
//   flush_req             : pulse to discard buffered and queued words
//   flush_busy/done       : flush in progress / one-cycle completion pulse
//   rd_count              : delivered-word count, wraps
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  input  logic             flush_req,
  output logic             flush_busy,
  output logic             flush_done,
  output logic [CNT_W-1:0] rd_count
);

  localparam int unsigned CMT_W = OCC_W + 1;

  rd_state_e        state_q, state_d;
  logic             inflight_q;
  logic [CNT_W-1:0] rd_count_q;
  logic [OCC_W-1:0] occ;
  logic [WIDTH-1:0] head;
  logic [CMT_W-1:0] committed;
  logic             push, pop, clear;

  // Words already owned by the buffer, including one still in the FIFO read stage.
  assign committed = CMT_W'(occ) + CMT_W'(inflight_q);

  // State register, read pipeline flag and delivered-word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      inflight_q <= 1'b0;
      rd_count_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_rd_en;
      if (pop) rd_count_q <= rd_count_q + CNT_W'(1);
    end
  end

  // Next-state and stream/read control.
  always_comb begin
    state_d    = state_q;
    fifo_rd_en = 1'b0;
    m_valid    = 1'b0;
    flush_busy = 1'b0;
    flush_done = 1'b0;
    clear      = 1'b0;
    case (state_q)
      RUN: begin
        m_valid    = (occ != '0);
        fifo_rd_en = rst_n && !fifo_empty && (committed < CMT_W'(SKID_DEPTH));
        if (flush_req) begin
          state_d = FLUSH;
          clear   = 1'b1;
        end
      end
      FLUSH: begin
        flush_busy = 1'b1;
        fifo_rd_en = rst_n && !fifo_empty;
        if (fifo_empty && !inflight_q) state_d = DONE;
      end
      DONE: begin
        flush_busy = 1'b1;
        flush_done = 1'b1;
        state_d    = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Returning data is only kept in RUN; during FLUSH it is dropped on arrival.
  assign push = inflight_q && (state_q == RUN);
  assign pop  = m_valid && m_ready;

  fifo_skid_buf #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (clear),
    .push_i      (push),
    .push_data_i (fifo_data),
    .pop_i       (pop),
    .head_o      (head),
    .occ_o       (occ)
  );

  assign m_data   = head;
  assign rd_count = rd_count_q;

endmodule : fifo_reader

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader (WIDTH=8, CNT_W=4) with an upstream FIFO model.
module tb_fifo_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_data = 8'h00;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       flush_req = 1'b0;
  logic       flush_busy;
  logic       flush_done;
  logic [3:0] rd_count;

  logic [7:0] up_mem [4096];
  logic [7:0] out_mem [2048];
  int wr_cnt = 0;
  int up_rd_cnt = 0;
  int rd_issued = 0;
  int bad_rd = 0;
  int out_cnt = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (wr_cnt == up_rd_cnt);

  fifo_reader #(
    .WIDTH (8),
    .CNT_W (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .flush_req  (flush_req),
    .flush_busy (flush_busy),
    .flush_done (flush_done),
    .rd_count   (rd_count)
  );

  // Upstream FIFO: registered read data, not affected by the reader's reset.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      rd_issued <= rd_issued + 1;
      if (up_rd_cnt == wr_cnt) begin
        bad_rd <= bad_rd + 1;
      end else begin
        fifo_data <= up_mem[12'(up_rd_cnt)];
        up_rd_cnt <= up_rd_cnt + 1;
      end
    end
  end

  // Output stream capture.
  always @(posedge clk) begin
    if (m_valid && m_ready) begin
      out_mem[11'(out_cnt)] <= m_data;
      out_cnt <= out_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] w);
    up_mem[12'(wr_cnt)] = w;
    wr_cnt = wr_cnt + 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({m_valid, fifo_rd_en, flush_busy, flush_done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=0000", {m_valid, fifo_rd_en, flush_busy, flush_done});
    end
    checks++;
    if (m_data !== 8'h00 || rd_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_data m_data=%h rd_count=%0d exp 00/0", m_data, rd_count);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    logic [7:0] exp_w [4];
    int base, r0;
    exp_w[0] = 8'h11; exp_w[1] = 8'h22; exp_w[2] = 8'h33; exp_w[3] = 8'h44;
    base = out_cnt;
    r0 = rd_issued;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(exp_w[i]);
    #1;
    checks++;
    if (fifo_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL stream_rd_en got=%b exp=1", fifo_rd_en);
    end
    tick();
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_latency1 m_valid=%b exp=0", m_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (m_valid !== 1'b1 || m_data !== exp_w[i]) begin
        errors++;
        $display("FAIL stream_beat%0d valid=%b data=%h exp 1/%h", i, m_valid, m_data, exp_w[i]);
      end
    end
    tick();
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_end m_valid=%b exp=0", m_valid);
    end
    tick();
    checks++;
    if (rd_count !== 4'd4 || (rd_issued - r0) != 4 || (out_cnt - base) != 4 || bad_rd != 0) begin
      errors++;
      $display("FAIL stream_counts rd_count=%0d reads=%0d outs=%0d bad_rd=%0d exp 4/4/4/0",
               rd_count, rd_issued - r0, out_cnt - base, bad_rd);
    end
  endtask

  task automatic test_backpressure();
    int base, r0, nbad, cyc;
    base = out_cnt;
    r0 = rd_issued;
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) push_word(8'(8'hA0 + i));
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if ((rd_issued - r0) != 3 || fifo_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL bp_reads reads=%0d rd_en=%b exp 3/0", rd_issued - r0, fifo_rd_en);
    end
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hA0) begin
      errors++;
      $display("FAIL bp_hold1 valid=%b data=%h exp 1/a0", m_valid, m_data);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hA0) begin
      errors++;
      $display("FAIL bp_hold2 valid=%b data=%h exp 1/a0", m_valid, m_data);
    end
    m_ready = 1'b1;
    cyc = 0;
    while ((out_cnt - base) < 10 && cyc < 60) begin
      tick();
      cyc++;
    end
    for (int i = 0; i < 4; i++) tick();
    nbad = 0;
    for (int i = 0; i < 10; i++) if (out_mem[11'(base + i)] !== 8'(8'hA0 + i)) nbad++;
    checks++;
    if ((out_cnt - base) != 10 || nbad != 0) begin
      errors++;
      $display("FAIL bp_sequence outs=%0d bad=%0d exp 10/0", out_cnt - base, nbad);
    end
    checks++;
    if (rd_count !== 4'd14) begin
      errors++;
      $display("FAIL bp_count rd_count=%0d exp=14", rd_count);
    end
  endtask

  task automatic test_random();
    int base, nbad, cyc;
    base = out_cnt;
    for (int i = 0; i < 1000; i++) push_word(8'(i * 7 + 3));
    cyc = 0;
    while ((out_cnt - base) < 1000 && cyc < 6000) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    nbad = 0;
    for (int i = 0; i < 1000; i++) if (out_mem[11'(base + i)] !== 8'(i * 7 + 3)) nbad++;
    checks++;
    if ((out_cnt - base) != 1000 || nbad != 0) begin
      errors++;
      $display("FAIL rand_sequence outs=%0d bad=%0d exp 1000/0", out_cnt - base, nbad);
    end
    // 14 + 1000 = 1014 delivered so far; 1014 mod 16 = 6.
    checks++;
    if (rd_count !== 4'd6 || bad_rd != 0) begin
      errors++;
      $display("FAIL rand_count rd_count=%0d bad_rd=%0d exp 6/0", rd_count, bad_rd);
    end
  endtask

  task automatic test_flush();
    int base, r0, r1, n_done, done_at;
    base = out_cnt;
    r0 = rd_issued;
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(8'(8'hC0 + i));
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if ((rd_issued - r0) != 3 || m_valid !== 1'b1 || m_data !== 8'hC0) begin
      errors++;
      $display("FAIL flush_prefill reads=%0d valid=%b data=%h exp 3/1/c0", rd_issued - r0, m_valid, m_data);
    end
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    r1 = rd_issued;
    checks++;
    if (m_valid !== 1'b0 || flush_busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_enter valid=%b busy=%b exp 0/1", m_valid, flush_busy);
    end
    n_done = 0;
    done_at = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (flush_done === 1'b1) begin
        n_done++;
        done_at = i;
      end
    end
    checks++;
    if (n_done != 1 || done_at != 7) begin
      errors++;
      $display("FAIL flush_done pulses=%0d at=%0d exp 1/7", n_done, done_at);
    end
    checks++;
    if ((rd_issued - r1) != 5 || fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL flush_drain reads=%0d empty=%b exp 5/1", rd_issued - r1, fifo_empty);
    end
    checks++;
    if (flush_busy !== 1'b0 || m_valid !== 1'b0 || rd_count !== 4'd6) begin
      errors++;
      $display("FAIL flush_exit busy=%b valid=%b rd_count=%0d exp 0/0/6", flush_busy, m_valid, rd_count);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (out_cnt != base) begin
      errors++;
      $display("FAIL flush_no_output outs=%0d exp=0", out_cnt - base);
    end
  endtask

  task automatic test_reset_midstream();
    int base, cyc;
    base = out_cnt;
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(8'(8'h51 + i));
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h51 || fifo_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL rstm_pre valid=%b data=%h rd_en=%b exp 1/51/0", m_valid, m_data, fifo_rd_en);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({m_valid, fifo_rd_en, flush_busy, flush_done} !== 4'b0000 || m_data !== 8'h00 || rd_count !== 4'd0) begin
      errors++;
      $display("FAIL rstm_outputs ctrl=%b data=%h rd_count=%0d exp 0000/00/0",
               {m_valid, fifo_rd_en, flush_busy, flush_done}, m_data, rd_count);
    end
    #2 rst_n = 1'b1;
    m_ready = 1'b1;
    cyc = 0;
    while ((out_cnt - base) < 3 && cyc < 30) begin
      tick();
      cyc++;
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if ((out_cnt - base) != 3 || out_mem[11'(base)] !== 8'h54 ||
        out_mem[11'(base + 1)] !== 8'h55 || out_mem[11'(base + 2)] !== 8'h56) begin
      errors++;
      $display("FAIL rstm_resume outs=%0d first=%h exp 3/54", out_cnt - base, out_mem[11'(base)]);
    end
    checks++;
    if (rd_count !== 4'd3) begin
      errors++;
      $display("FAIL rstm_count rd_count=%0d exp=3", rd_count);
    end
  endtask

  task automatic test_wrap();
    int base, cyc;
    logic seen15, seen_wrap;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    checks++;
    if (rd_count !== 4'd0) begin
      errors++;
      $display("FAIL wrap_start rd_count=%0d exp=0", rd_count);
    end
    base = out_cnt;
    seen15 = 1'b0;
    seen_wrap = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 17; i++) push_word(8'(8'h60 + i));
    cyc = 0;
    while ((out_cnt - base) < 17 && cyc < 60) begin
      tick();
      cyc++;
      if (rd_count === 4'd15) seen15 = 1'b1;
      if (seen15 && rd_count === 4'd0) seen_wrap = 1'b1;
    end
    tick();
    checks++;
    if (seen15 !== 1'b1 || seen_wrap !== 1'b1) begin
      errors++;
      $display("FAIL wrap_path seen15=%b seen_wrap=%b exp 1/1", seen15, seen_wrap);
    end
    checks++;
    if (rd_count !== 4'd1 || (out_cnt - base) != 17 || out_mem[11'(base + 16)] !== 8'h70) begin
      errors++;
      $display("FAIL wrap_end rd_count=%0d outs=%0d last=%h exp 1/17/70",
               rd_count, out_cnt - base, out_mem[11'(base + 16)]);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_random();
    test_flush();
    test_reset_midstream();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fifo_reader

// File: doc/fifo_reader.md
Name: fifo_reader

Overview:
Read-side controller that drains an upstream synchronous FIFO and presents its words as a valid/ready stream. The upstream FIFO has registered read data, one cycle of latency and an empty flag.
- Absorbs the read latency with a 3-entry skid buffer, so it sustains one word per cycle with no combinational path from m_ready to fifo_rd_en.
- Provides a flush operation that discards all buffered and queued words.
- Counts delivered words.

Parameters:
WIDTH, 8, data word width (must match upstream FIFO)
CNT_W, 16, width of delivered-word counter

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
fifo_empty  in  1  upstream FIFO empty flag
fifo_rd_en  out  1  read request to upstream FIFO
fifo_data  in  WIDTH  upstream registered read data, valid the cycle after an accepted read
m_valid  out  1  output stream valid
m_ready  in  1  output stream ready
m_data  out  WIDTH  output stream data (skid buffer head)
flush_req  in  1  single-cycle flush request
flush_busy  out  1  high while flush in progress (FLUSH or DONE)
flush_done  out  1  one-cycle pulse when flush completes
rd_count  out  CNT_W  number of words delivered (m_valid && m_ready), wraps modulo 2^CNT_W

Behaviour:
- Interface decision: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset (rst_n low, async):
  - state=RUN, buffer empty, inflight=0, rd_count=0.
  - m_valid=0, m_data=0, flush_busy=0, flush_done=0.
  - fifo_rd_en is gated with rst_n, so it is 0 during reset.
  - Reset mid-operation silently drops in-flight and buffered words.
- Accepted read: fifo_rd_en=1 at a rising edge; fifo_rd_en is only driven high when fifo_empty=0.
- inflight: register, set to 1 for exactly the cycle after an accepted read.
- Data capture: when inflight=1, fifo_data is pushed into the skid buffer at the next edge. Read-to-capture is 2 edges; capture-to-m_valid is 0 cycles, because m_data is the buffer head register.
- RUN read issue: fifo_rd_en = rst_n && state==RUN && !fifo_empty && (occ + inflight) < 3.
  - occ is the buffer occupancy, 0..3.
  - This uses registered terms plus fifo_empty only.
  - Steady-state throughput with m_ready=1 is 1 word/cycle.
  - The buffer never overflows. Overflow is an assertion target: a push with occ==3 and no pop.
- Output stream:
  - m_valid = (occ != 0) && state==RUN.
  - Pop on m_valid && m_ready.
  - m_data and m_valid hold stable while m_valid && !m_ready.
  - Only exception: flush, which withdraws m_valid.
- Simultaneous push and pop in the same edge: occ unchanged, order preserved (FIFO order throughout).
- rd_count increments by 1 per pop; 2^CNT_W-1 wraps to 0. Flushed words are not counted.
- FSM states RUN, FLUSH, DONE:
  - RUN -> FLUSH on flush_req=1. At that edge the buffer is cleared; any in-flight word is discarded on arrival. A pop coincident with flush_req still counts (handshake completed).
  - FLUSH:
    - m_valid=0.
    - fifo_rd_en = rst_n && !fifo_empty.
    - Returning data is discarded, not buffered.
    - Exit to DONE at an edge where fifo_empty=1 and inflight=0.
    - No timeout: if the writer keeps writing, FLUSH persists.
  - DONE: flush_done=1 for exactly this cycle; fifo_rd_en=0. Next state is RUN unconditionally.
  - flush_busy=1 in FLUSH and DONE.
  - flush_req is ignored in FLUSH and DONE.
- Empty upstream in RUN: fifo_rd_en=0. m_valid stays high while buffered words remain.

Decomposition:
- Package fifo_reader_pkg:
  - enum rd_state_e {RUN, FLUSH, DONE}
  - localparam SKID_DEPTH=3
  - localparam OCC_W=2
- Sub-module fifo_skid_buf:
  - 3-entry register FIFO with push, pop, clear, head data, occ.
  - Parameterised on WIDTH.
  - Same clk/rst_n.

Test Plan:
1. Upstream holds 0x11,0x22,0x33,0x44; m_ready=1 -> first m_valid 2 cycles after the first fifo_rd_en; then 4 consecutive beats 0x11..0x44; rd_count=4; fifo_rd_en never high while fifo_empty=1.
2. Upstream holds 10 words; m_ready=0 -> exactly 3 reads issued, fifo_rd_en then 0; m_data=first word held stable; release m_ready -> 10 words in order, no loss or duplication.
3. Random m_ready (50%) with a continuously filled upstream, 1000 words -> output sequence equals input sequence, rd_count=1000, no skid overflow assertion.
4. Buffer holds 3 words and upstream holds 5, then a flush_req pulse -> m_valid drops the next cycle; 5 reads issued during FLUSH; flush_done pulses once after empty and inflight=0; return to RUN; rd_count unchanged.
5. CNT_W=4, 17 words delivered -> rd_count reaches 15, wraps to 0, ends at 1.
6. rst_n low asynchronously mid-stream (between edges) with occ=2 and inflight=1 -> all outputs 0 immediately; after release, the next word read is the upstream head and no stale data appears.
